lsu_mem_stage: RTL and testbench

Load/store unit for the MEM stage of the 5-stage core. It consumes the EX/MEM outputs (ALUResultM as address, WriteDataM as store data) and produces ReadDataM for the MEM/WB register. It drives a req/gnt/rvalid data bus with byte enables, and performs sub-word alignment and sign/zero extension. It raises StallM, which the hazard unit ORs into the whole-pipeline stall, while a bus access is outstanding.

---
 rtl/lsu_mem_stage.sv | 250 +++++++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit for the 5-stage core.
// Issues one req/gnt/rvalid bus access per load/store, replicates store
// data across byte lanes, and extracts/extends sub-word load data.
// StallM holds the pipeline while an access is outstanding; FaultM pulses
// for misaligned or illegal accesses.
// Optional build macro: LSU_TIMEOUT_EN adds a bus watchdog of TIMEOUT_CYC
// cycles. Without it the unit waits for the bus indefinitely.
module lsu_mem_stage #(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [2:0]      Funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ReadDataM,
    output logic            StallM,
    output logic            FaultM,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_REQ    = 2'b01,
        S_WAIT_R = 2'b10,
        S_DONE   = 2'b11
    } state_t;

    // Byte enables for the access size; half-words stay on an aligned pair.
    function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Select the addressed byte/half from the read word and extend it.
    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                    input logic [XLEN-1:0] data);
        logic [XLEN-1:0] shifted;
        shifted = data >> {off, 3'b000};
        case (f3)
            3'b000:  return {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  return {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  return {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  return {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: return data;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = 16;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`endif

    logic access_s;
    logic legal_f3_s;
    logic misalign_s;
    logic fault_s;
    logic stall_s;
    logic fault_out_s;

    // Decode the incoming access: legality of funct3 and alignment.
    always_comb begin
        access_s   = MemReadM | MemWriteM;
        legal_f3_s = 1'b0;
        misalign_s = 1'b0;
        case (Funct3M)
            3'b000, 3'b001, 3'b010: legal_f3_s = 1'b1;
            3'b100, 3'b101:         legal_f3_s = ~MemWriteM;
            default:                legal_f3_s = 1'b0;
        endcase
        case (Funct3M[1:0])
            2'b01:   misalign_s = ALUResultM[0];
            2'b10:   misalign_s = (ALUResultM[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
        fault_s = access_s & (~legal_f3_s | misalign_s);
    end

    // Next-state, bus-request capture and load-data capture.
    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        off_d       = off_q;
        stall_s     = 1'b0;
        fault_out_s = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
        tmo_d       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (fault_s) begin
                    fault_out_s = 1'b1;
                    rdata_d     = '0;
                end else if (access_s) begin
                    stall_s = 1'b1;
                    addr_d  = {ALUResultM[XLEN-1:2], 2'b00};
                    we_d    = MemWriteM;
                    be_d    = calc_be(Funct3M, ALUResultM[1:0]);
                    f3_d    = Funct3M;
                    off_d   = ALUResultM[1:0];
                    req_d   = 1'b1;
                    state_d = S_REQ;
                    if (MemWriteM) begin
                        case (Funct3M[1:0])
                            2'b00:   wdata_d = {(XLEN/8){WriteDataM[7:0]}};
                            2'b01:   wdata_d = {(XLEN/16){WriteDataM[15:0]}};
                            default: wdata_d = WriteDataM;
                        endcase
                    end else begin
                        wdata_d = '0;
                    end
`ifdef LSU_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                stall_s = 1'b1;
                if (bus_gnt) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = S_DONE;
                    end else if (bus_rvalid) begin
                        rdata_d = load_extend(f3_q, off_q, bus_rdata);
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_R;
                    end
                end else begin
`ifdef LSU_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        req_d   = 1'b0;
                        rdata_d = '0;
                        tmo_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_WAIT_R: begin
                stall_s = 1'b1;
                if (bus_rvalid) begin
                    rdata_d = load_extend(f3_q, off_q, bus_rdata);
                    state_d = S_DONE;
                end else begin
`ifdef LSU_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        rdata_d = '0;
                        tmo_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    state_d = S_WAIT_R;
`endif
                end
            end
            S_DONE: begin
`ifdef LSU_TIMEOUT_EN
                fault_out_s = tmo_q;
`endif
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any outstanding access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Stall/fault depend on live inputs, so they are forced low during reset.
    assign StallM    = reset & stall_s;
    assign FaultM    = reset & fault_out_s;
    assign ReadDataM = rdata_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed testbench for lsu_mem_stage. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_lsu_mem_stage;

    logic        clk;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        FaultM;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    lsu_mem_stage #(.XLEN(32), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .FaultM(FaultM),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    // 10-unit core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Load with gnt and rvalid together on the first REQ cycle.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_data);
        nxt();
        MemReadM = 1'b1; Funct3M = f3; ALUResultM = addr;
        smp();
        chk({tag, "_idle_stall"}, 32'(StallM), 32'd1);
        nxt();
        bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = rdata;
        smp();
        chk({tag, "_be"}, 32'(bus_be), 32'(exp_be));
        chk({tag, "_addr"}, bus_addr, {addr[31:2], 2'b00});
        nxt();
        bus_gnt = 1'b0; bus_rvalid = 1'b0; MemReadM = 1'b0;
        smp();
        chk({tag, "_done_stall"}, 32'(StallM), 32'd0);
        chk({tag, "_data"}, ReadDataM, exp_data);
    endtask

    // Access that must fault in IDLE without touching the bus.
    task automatic do_fault(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr);
        nxt();
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = 32'h1111_2222;
        smp();
        chk({tag, "_fault"}, 32'(FaultM), 32'd1);
        chk({tag, "_stall"}, 32'(StallM), 32'd0);
        chk({tag, "_req"}, 32'(bus_req), 32'd0);
        nxt();
        MemReadM = 1'b0; MemWriteM = 1'b0;
        smp();
        chk({tag, "_pulse"}, 32'(FaultM), 32'd0);
        chk({tag, "_req2"}, 32'(bus_req), 32'd0);
        chk({tag, "_rdata"}, ReadDataM, 32'h0000_0000);
    endtask

    initial begin
        reset = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
        ALUResultM = 32'h0; WriteDataM = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;

        // Reset state
        smp();
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_stall", 32'(StallM), 32'd0);
        chk("rst_fault", 32'(FaultM), 32'd0);
        chk("rst_rdata", ReadDataM, 32'h0);
        chk("rst_be", 32'(bus_be), 32'd0);
        nxt();
        reset = 1'b1;

        // 1: lw 0x100, gnt on second REQ cycle, rvalid one cycle later
        nxt();
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h0000_0100;
        smp();
        chk("t1_idle_stall", 32'(StallM), 32'd1);
        chk("t1_idle_req", 32'(bus_req), 32'd0);
        nxt();
        smp();
        chk("t1_req1", 32'(bus_req), 32'd1);
        chk("t1_addr", bus_addr, 32'h0000_0100);
        chk("t1_be", 32'(bus_be), 32'h0000_000F);
        chk("t1_we", 32'(bus_we), 32'd0);
        chk("t1_req1_stall", 32'(StallM), 32'd1);
        nxt();
        bus_gnt = 1'b1;
        smp();
        chk("t1_req2", 32'(bus_req), 32'd1);
        chk("t1_req2_stall", 32'(StallM), 32'd1);
        nxt();
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
        smp();
        chk("t1_wait_req", 32'(bus_req), 32'd0);
        chk("t1_wait_stall", 32'(StallM), 32'd1);
        nxt();
        bus_rvalid = 1'b0; MemReadM = 1'b0;
        smp();
        chk("t1_done_stall", 32'(StallM), 32'd0);
        chk("t1_data", ReadDataM, 32'h1234_5678);
        nxt();
        smp();
        chk("t1_idle_after", 32'(StallM), 32'd0);
        chk("t1_hold", ReadDataM, 32'h1234_5678);

        // 2: sub-word loads with sign/zero extension
        do_load("t2_lb", 3'b000, 32'h0000_0203, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80);
        do_load("t2_lbu", 3'b100, 32'h0000_0203, 32'h80FF_1234, 4'b1000, 32'h0000_0080);
        do_load("t2_lhu", 3'b101, 32'h0000_0202, 32'h80FF_1234, 4'b1100, 32'h0000_80FF);
        do_load("t2_lh", 3'b001, 32'h0000_0202, 32'h80FF_1234, 4'b1100, 32'hFFFF_80FF);
        do_load("t2_lb0", 3'b000, 32'h0000_0200, 32'h80FF_1234, 4'b0001, 32'h0000_0034);

        // 3: sh 0x102 with immediate gnt
        nxt();
        MemWriteM = 1'b1; Funct3M = 3'b001; ALUResultM = 32'h0000_0102; WriteDataM = 32'h0000_ABCD;
        smp();
        chk("t3_idle_stall", 32'(StallM), 32'd1);
        nxt();
        bus_gnt = 1'b1;
        smp();
        chk("t3_req", 32'(bus_req), 32'd1);
        chk("t3_we", 32'(bus_we), 32'd1);
        chk("t3_addr", bus_addr, 32'h0000_0100);
        chk("t3_be", 32'(bus_be), 32'h0000_000C);
        chk("t3_wdata", bus_wdata, 32'hABCD_ABCD);
        chk("t3_req_stall", 32'(StallM), 32'd1);
        nxt();
        bus_gnt = 1'b0; MemWriteM = 1'b0;
        smp();
        chk("t3_done_stall", 32'(StallM), 32'd0);
        chk("t3_done_req", 32'(bus_req), 32'd0);
        chk("t3_rdata_kept", ReadDataM, 32'h0000_0034);

        // sb 0x101 lane replication
        nxt();
        MemWriteM = 1'b1; Funct3M = 3'b000; ALUResultM = 32'h0000_0101; WriteDataM = 32'hFFFF_FF5A;
        nxt();
        bus_gnt = 1'b1;
        smp();
        chk("t3_sb_be", 32'(bus_be), 32'h0000_0002);
        chk("t3_sb_wdata", bus_wdata, 32'h5A5A_5A5A);
        nxt();
        bus_gnt = 1'b0; MemWriteM = 1'b0;

        // 4: faults (misaligned, illegal funct3) clear ReadDataM
        do_fault("t4_lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0101);
        do_load("t4_pre", 3'b010, 32'h0000_0300, 32'hA5A5_0F0F, 4'b1111, 32'hA5A5_0F0F);
        do_fault("t4_f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_0300);
        do_fault("t4_sw_mis", 1'b0, 1'b1, 3'b010, 32'h0000_0302);
        do_fault("t4_st_f3", 1'b0, 1'b1, 3'b100, 32'h0000_0300);
        do_fault("t4_lh_mis", 1'b1, 1'b0, 3'b001, 32'h0000_0303);

        // 5: reset during WAIT_R, then a late rvalid
        do_load("t5_pre", 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        nxt();
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h0000_0200;
        nxt();
        bus_gnt = 1'b1;
        nxt();
        bus_gnt = 1'b0;
        smp();
        chk("t5_wait_stall", 32'(StallM), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_req", 32'(bus_req), 32'd0);
        chk("t5_rst_stall", 32'(StallM), 32'd0);
        chk("t5_rst_rdata", ReadDataM, 32'h0);
        chk("t5_rst_addr", bus_addr, 32'h0);
        nxt();
        reset = 1'b1; MemReadM = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        smp();
        chk("t5_late_stall", 32'(StallM), 32'd0);
        chk("t5_late_req", 32'(bus_req), 32'd0);
        nxt();
        bus_rvalid = 1'b0;
        smp();
        chk("t5_late_rdata", ReadDataM, 32'h0);
        chk("t5_late_stall2", 32'(StallM), 32'd0);

        // 6: bus never grants
        nxt();
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h0000_0500;
        nxt();
        smp();
        chk("t6_req_first", 32'(bus_req), 32'd1);
`ifdef LSU_TIMEOUT_EN
        for (int i = 0; i < 63; i++) nxt();
        smp();
        chk("t6_req_last", 32'(bus_req), 32'd1);
        chk("t6_req_last_stall", 32'(StallM), 32'd1);
        nxt();
        smp();
        chk("t6_tmo_fault", 32'(FaultM), 32'd1);
        chk("t6_tmo_req", 32'(bus_req), 32'd0);
        chk("t6_tmo_stall", 32'(StallM), 32'd0);
        chk("t6_tmo_rdata", ReadDataM, 32'h0);
        nxt();
        MemReadM = 1'b0;
        smp();
        chk("t6_tmo_pulse", 32'(FaultM), 32'd0);
        chk("t6_tmo_idle", 32'(StallM), 32'd0);
`else
        for (int i = 0; i < 100; i++) nxt();
        smp();
        chk("t6_still_req", 32'(bus_req), 32'd1);
        chk("t6_still_stall", 32'(StallM), 32'd1);
        chk("t6_no_fault", 32'(FaultM), 32'd0);
        nxt();
        bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_F00D;
        nxt();
        bus_gnt = 1'b0; bus_rvalid = 1'b0; MemReadM = 1'b0;
        smp();
        chk("t6_late_data", ReadDataM, 32'h0BAD_F00D);
        chk("t6_late_stall", 32'(StallM), 32'd0);
`endif

        nxt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
